// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: instruction/address words and the queue entry layout.
package fetch_pkg;

  typedef logic [31:0] inst_t;
  typedef logic [31:0] addr_t;

  localparam int unsigned INST_BYTES = 4;

  typedef struct packed {
    inst_t inst;
    addr_t pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction buffer: up to WIDTH writes and WIDTH reads per cycle, flush clears pointers.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int unsigned WIDTH = 3,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned NW    = $clog2(WIDTH + 1),
  localparam int unsigned CW    = $clog2(DEPTH + 1),
  localparam int unsigned PW    = $clog2(DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [NW-1:0]            wr_cnt_i,
  input  fetch_entry_t [WIDTH-1:0] wr_data_i,
  input  logic [NW-1:0]            rd_cnt_i,
  output fetch_entry_t [WIDTH-1:0] rd_data_o,
  output logic [CW-1:0]            count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // DEPTH is a power of two, so pointer wrap is plain truncation.
  always_comb begin
    head_d  = head_q + PW'(rd_cnt_i);
    tail_d  = tail_q + PW'(wr_cnt_i);
    count_d = count_q + CW'(wr_cnt_i) - CW'(rd_cnt_i);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && !flush_i) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (i < 32'(wr_cnt_i)) begin
          mem_q[PW'(tail_q + PW'(i))] <= wr_data_i[i];
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      rd_data_o[i] = mem_q[PW'(head_q + PW'(i))];
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC generator and I-cache request driver feeding an in-order instruction queue.
// Define FETCH_PERF_EN to add saturating miss/full/flush performance counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       ic_enable,
  output logic [31:0]                ic_pc,
  input  logic [WIDTH-1:0][31:0]     ic_data,
  input  logic [WIDTH-1:0]           ic_valid,
  input  logic                       redir_valid,
  input  logic [31:0]                redir_pc,
  output logic [WIDTH-1:0][31:0]     out_inst,
  output logic [WIDTH-1:0][31:0]     out_pc,
  output logic [WIDTH-1:0]           out_valid,
  input  logic [$clog2(WIDTH+1)-1:0] deq_cnt
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]                perf_miss_cyc,
  output logic [31:0]                perf_full_cyc,
  output logic [31:0]                perf_flush
`endif
);

  localparam int unsigned NW = $clog2(WIDTH + 1);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  addr_t                    pc_q, pc_d;
  logic [CW-1:0]            count;
  logic [CW-1:0]            free;
  logic [NW-1:0]            lead;
  logic                     hole;
  logic [NW-1:0]            acc_n;
  logic [NW-1:0]            deq_n;
  fetch_entry_t [WIDTH-1:0] wr_data;
  fetch_entry_t [WIDTH-1:0] rd_data;

  assign ic_enable = reset && !redir_valid && (count < CW'(DEPTH));
  assign ic_pc     = pc_q;
  assign free      = CW'(DEPTH) - count;

  // Only the contiguous run of hits from lane 0 is usable; anything past a gap is dropped.
  always_comb begin
    lead = '0;
    hole = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!hole && ic_valid[i]) begin
        lead = NW'(i + 1);
      end else begin
        hole = 1'b1;
      end
    end
  end

  always_comb begin
    acc_n = '0;
    if (ic_enable) begin
      acc_n = (CW'(lead) > free) ? NW'(free) : lead;
    end
  end

  always_comb begin
    deq_n = deq_cnt;
    if (32'(deq_n) > WIDTH) begin
      deq_n = NW'(WIDTH);
    end
    if (CW'(deq_n) > count) begin
      deq_n = NW'(count);
    end
    if (!reset || redir_valid) begin
      deq_n = '0;
    end
  end

  always_comb begin
    pc_d = pc_q + addr_t'(acc_n) * addr_t'(INST_BYTES);
    if (redir_valid) begin
      pc_d = redir_pc & ~addr_t'(INST_BYTES - 1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      wr_data[i].inst = ic_data[i];
      wr_data[i].pc   = pc_q + addr_t'(i * INST_BYTES);
    end
  end

  fetch_queue #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i     (clock),
    .rst_ni    (reset),
    .flush_i   (redir_valid),
    .wr_cnt_i  (acc_n),
    .wr_data_i (wr_data),
    .rd_cnt_i  (deq_n),
    .rd_data_o (rd_data),
    .count_o   (count)
  );

  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      out_valid[i] = reset && !redir_valid && (count > CW'(i));
      out_inst[i]  = out_valid[i] ? rd_data[i].inst : '0;
      out_pc[i]    = out_valid[i] ? rd_data[i].pc   : '0;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] miss_q, full_q, flush_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      miss_q  <= '0;
      full_q  <= '0;
      flush_q <= '0;
    end else begin
      if (ic_enable && !ic_valid[0] && (miss_q != '1)) begin
        miss_q <= miss_q + 32'd1;
      end
      if ((count == CW'(DEPTH)) && (full_q != '1)) begin
        full_q <= full_q + 32'd1;
      end
      if (redir_valid && (flush_q != '1)) begin
        flush_q <= flush_q + 32'd1;
      end
    end
  end

  assign perf_miss_cyc = miss_q;
  assign perf_full_cyc = full_q;
  assign perf_flush    = flush_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus queues expected (inst, pc) pairs, a monitor checks dequeued lanes.
`timescale 1ns/1ps
module tb_fetch_stage;

  localparam int unsigned WIDTH = 3;
  localparam int unsigned DEPTH = 8;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   ic_enable;
  logic [31:0]            ic_pc;
  logic [WIDTH-1:0][31:0] ic_data;
  logic [WIDTH-1:0]       ic_valid;
  logic                   redir_valid;
  logic [31:0]            redir_pc;
  logic [WIDTH-1:0][31:0] out_inst;
  logic [WIDTH-1:0][31:0] out_pc;
  logic [WIDTH-1:0]       out_valid;
  logic [1:0]             deq_cnt;

  always #5 clock = ~clock;

  fetch_stage #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .ic_enable   (ic_enable),
    .ic_pc       (ic_pc),
    .ic_data     (ic_data),
    .ic_valid    (ic_valid),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .out_valid   (out_valid),
    .deq_cnt     (deq_cnt)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'h5A00_0000 ^ (pc * 32'h0101_0001);
  endfunction

  // Lanes consumed by decode on the coming edge are compared against the oldest expectations.
  always @(negedge clock) begin : monitor
    int   lanes;
    exp_t e;
    lanes = 0;
    for (int i = 0; i < int'(WIDTH); i++) if (out_valid[i] === 1'b1) lanes++;
    if (int'(deq_cnt) < lanes) lanes = int'(deq_cnt);
    if (reset !== 1'b1 || redir_valid !== 1'b0) lanes = 0;
    for (int i = 0; i < lanes; i++) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL deq_underflow: got pc %h want no valid lane", out_pc[i]);
      end else begin
        e = exp_q.pop_front();
        chk("deq_inst", out_inst[i], e.inst);
        chk("deq_pc", out_pc[i], e.pc);
      end
    end
  end

  task automatic idle();
    ic_valid    = '0;
    ic_data     = '0;
    deq_cnt     = '0;
    redir_valid = 1'b0;
    redir_pc    = '0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    idle();
    #1;
  endtask

  task automatic hit(input logic [2:0] v, input logic [31:0] pc, input int n_acc, input logic [1:0] dq);
    ic_valid = v;
    for (int i = 0; i < int'(WIDTH); i++) ic_data[i] = word_at(pc + 32'(4 * i));
    for (int i = 0; i < n_acc; i++) exp_q.push_back({word_at(pc + 32'(4 * i)), pc + 32'(4 * i)});
    deq_cnt = dq;
  endtask

  initial begin
    logic [31:0] mpc;
    int          mcnt, n, d;

    reset = 1'b0;
    idle();
    step();
    step();
    chk("rst_ic_enable", 32'(ic_enable), 32'd0);
    chk("rst_ic_pc", ic_pc, 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_inst0", out_inst[0], 32'h0);
    chk("rst_out_pc2", out_pc[2], 32'h0);

    reset = 1'b1;
    #1;
    chk("rel_ic_enable", 32'(ic_enable), 32'd1);
    chk("rel_ic_pc", ic_pc, 32'h0);
    chk("rel_out_valid", 32'(out_valid), 32'd0);

    // Misses: PC holds, nothing queued
    for (int c = 0; c < 3; c++) begin
      ic_valid   = 3'b000;
      ic_data[0] = 32'hdeadbeef;
      step();
      chk("miss_ic_pc", ic_pc, 32'h0);
      chk("miss_out_valid", 32'(out_valid), 32'd0);
      chk("miss_ic_enable", 32'(ic_enable), 32'd1);
    end

    ic_valid   = 3'b011;
    ic_data[0] = 32'hdeadbeef;
    ic_data[1] = 32'hcc00ffee;
    ic_data[2] = 32'h1234_5678;
    exp_q.push_back({32'hdeadbeef, 32'h0});
    exp_q.push_back({32'hcc00ffee, 32'h4});
    step();
    chk("hit_out_valid", 32'(out_valid), 32'b011);
    chk("hit_inst0", out_inst[0], 32'hdeadbeef);
    chk("hit_pc1", out_pc[1], 32'h4);
    chk("hit_ic_pc", ic_pc, 32'h8);
    chk("hit_lane2_zero", out_inst[2], 32'h0);

    // Gap: lane 2 set behind a clear lane 1 is dropped
    hit(3'b101, 32'h8, 1, 2'd0);
    step();
    chk("gap_ic_pc", ic_pc, 32'hC);
    chk("gap_out_valid", 32'(out_valid), 32'b111);
    chk("gap_pc2", out_pc[2], 32'h8);
    chk("gap_inst2", out_inst[2], word_at(32'h8));

    // Fill to DEPTH; last reply only partially fits
    hit(3'b111, 32'hC, 3, 2'd0);
    step();
    chk("fill_ic_pc", ic_pc, 32'h18);
    hit(3'b111, 32'h18, 2, 2'd0);
    step();
    chk("full_ic_pc", ic_pc, 32'h20);
    chk("full_ic_enable", 32'(ic_enable), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'b111);

    // Dequeue on the full cycle frees slots only for the next cycle
    hit(3'b111, 32'h20, 0, 2'd3);
    step();
    chk("full_deq_pc_hold", ic_pc, 32'h20);
    chk("full_deq_ic_enable", 32'(ic_enable), 32'd1);
    chk("full_deq_head_pc", out_pc[0], 32'hC);
    hit(3'b111, 32'h20, 3, 2'd0);
    step();
    chk("refill_ic_pc", ic_pc, 32'h2C);
    chk("refill_ic_enable", 32'(ic_enable), 32'd0);

    // Redirect with 5 queued entries and a simultaneous hit
    deq_cnt = 2'd3;
    step();
    chk("pre_redir_ic_enable", 32'(ic_enable), 32'd1);
    chk("pre_redir_head_pc", out_pc[0], 32'h18);
    hit(3'b111, 32'h2C, 0, 2'd3);
    redir_valid = 1'b1;
    redir_pc    = 32'h103;
    #1;
    chk("redir_out_valid", 32'(out_valid), 32'd0);
    chk("redir_ic_enable", 32'(ic_enable), 32'd0);
    step();
    exp_q.delete();
    chk("post_redir_out_valid", 32'(out_valid), 32'd0);
    chk("post_redir_ic_pc", ic_pc, 32'h100);
    chk("post_redir_ic_enable", 32'(ic_enable), 32'd1);

    // Sustained enqueue/dequeue across many pointer wraps
    mpc  = 32'h100;
    mcnt = 0;
    for (int c = 0; c < 30; c++) begin
      n = (int'(DEPTH) - mcnt < 3) ? int'(DEPTH) - mcnt : 3;
      d = (mcnt < 2) ? mcnt : 2;
      hit(3'b111, mpc, n, 2'd2);
      step();
      mpc  = mpc + 32'(4 * n);
      mcnt = mcnt + n - d;
      chk("wrap_ic_pc", ic_pc, mpc);
    end
    chk("wrap_out_valid", 32'(out_valid), 32'b111);
    chk("wrap_head_pc", out_pc[0], exp_q[0].pc);
    chk("wrap_lane2_pc", out_pc[2], exp_q[2].pc);

    // Drain, then over-request with one entry left
    deq_cnt = 2'd3;
    step();
    deq_cnt = 2'd2;
    step();
    chk("drain_out_valid", 32'(out_valid), 32'b001);
    deq_cnt = 2'd3;
    step();
    chk("clamp_out_valid", 32'(out_valid), 32'd0);
    chk("clamp_ic_enable", 32'(ic_enable), 32'd1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
